regfile_dump_reader: RTL
========================

# regfile_dump_reader

Sequential read-out engine for the 32-entry RegisterFile. On a start pulse it walks register addresses from x0 up to x31 through one RegisterFile read port (rs1 or rs2). It streams each {address, data} pair out over a valid/ready handshake. Used for debug/state dump and by benches to check architectural state without poking internal arrays; it is the read-side counterpart of the writeback path that drives rd/write_data/reg_write.

## Interface
- NUM_REGS, default 32, number of registers walked (addresses 0..NUM_REGS-1)
- ADDR_W, default 5, register address width
- DATA_W, default 32, register data width

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin dump; honoured only in IDLE
- abort  input  1  cancel dump in progress; return to IDLE
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after last beat accepted
- rf_raddr  output  ADDR_W  read address to RegisterFile rs1/rs2 port
- rf_rdata  input  DATA_W  combinational read data from RegisterFile
- out_valid  output  1  beat available
- out_ready  input  1  consumer accepts beat
- out_addr  output  ADDR_W  register index of current beat
- out_data  output  DATA_W  register value of current beat
- out_last  output  1  current beat is the final one

## Operation
- FSM states: IDLE, READ, HOLD, FINISH.
- IDLE: busy=0, out_valid=0. start=1 -> load addr counter with first address (0, or 1 with skip macro), go READ.
- READ: rf_raddr=counter; capture rf_rdata into out_data and counter into out_addr; set out_last when counter==NUM_REGS-1; go HOLD.
- HOLD: out_valid=1; out_addr/out_data/out_last stable until accepted.
  - out_ready=1 and out_last=0: increment counter, go READ.
  - out_ready=1 and out_last=1: go FINISH.
- FINISH: done=1 for exactly one cycle, go IDLE.
- abort=1 in READ/HOLD/FINISH -> IDLE next edge; out_valid drops without acceptance; no done pulse. abort has priority over out_ready.
- start while busy: ignored. start and abort together in IDLE: start wins.
- rf_raddr holds the counter value in all states and reads 0 in IDLE.
- Data is sampled in READ only. A RegisterFile write to an already-captured address is not reflected in that beat.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_addr=0, out_data=0, rf_raddr=0; state IDLE; counter 0.
- Reset mid-dump: immediate return to IDLE values, asynchronously.
- start sampled at edge N: READ during cycle N+1; first out_valid visible at cycle N+2.
- Throughput: one beat per 2 cycles with out_ready held high. Full dump of 32 registers = 64 cycles from start to done pulse, plus the FINISH cycle.
- Backpressure: any number of out_ready=0 cycles extends HOLD. No beat is lost or duplicated.
- Counter never wraps: last address terminates the walk.

## Configuration
- REGDUMP_SKIP_X0_EN defined: walk starts at address 1 (x0 hardwired zero, not emitted); NUM_REGS-1 beats.
- Undefined: walk starts at 0; NUM_REGS beats, x0 beat carries 0.

## Structure
- Shared package regdump_pkg: state enum type (IDLE/READ/HOLD/FINISH), default width constants, first-address constant selected by REGDUMP_SKIP_X0_EN.
- Single flat module; no sub-module warranted (FSM plus counter plus output register).

## Test plan
- Reset, then write x1=0xDEADBEEF and x2=0xCAFEBABE via RegisterFile, pulse start with out_ready=1. Required beats: (0,0x00000000), (1,0xDEADBEEF), (2,0xCAFEBABE), (3..31,0). out_last only on addr 31; done pulses one cycle after; total 65 cycles.
- Same preload, out_ready low for 5 cycles on beat addr 1. out_valid stays high, and out_addr=1 and out_data=0xDEADBEEF stay stable throughout. Stream resumes with addr 2, with no duplicate and no gap.
- Assert abort during HOLD of addr 7. Next cycle busy=0 and out_valid=0; no done pulse. A new start then restarts from addr 0.
- Assert rst while in HOLD of addr 12. All outputs go to reset values immediately; start afterwards gives a full dump.
- Pulse start again during a dump in progress. Required: no effect on sequence or counter.
- Build with REGDUMP_SKIP_X0_EN. Required: first beat (1,0xDEADBEEF), 31 beats total, out_last on addr 31.

Source files
------------

// File: rtl/regdump_pkg.sv
// rtl/regdump_pkg.sv - shared types and constants for the register file dump reader
// REGDUMP_SKIP_X0_EN selects a walk that starts at x1 instead of x0.
package regdump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    FINISH
  } state_t;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

`ifdef REGDUMP_SKIP_X0_EN
  // x0 is hardwired zero, so it carries no information worth emitting
  localparam int FIRST_ADDR = 1;
`else
  localparam int FIRST_ADDR = 0;
`endif

endpackage

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - control, register file read port and beat stream of the dump reader
// master is the dump engine; slave is the controller / register file / beat consumer side.
interface regfile_dump_reader_if
  import regdump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, abort, rf_rdata, out_ready,
    output busy, done, rf_raddr, out_valid, out_addr, out_data, out_last
  );

  modport slave (
    output start, abort, rf_rdata, out_ready,
    input  busy, done, rf_raddr, out_valid, out_addr, out_data, out_last
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks the register file addresses and streams {addr, data} beats
// REGDUMP_SKIP_X0_EN (via regdump_pkg) starts the walk at x1.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_dump_reader_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FIRST_ADDR);

  state_t            r_state;
  logic [ADDR_W-1:0] r_counter;
  logic              r_busy;
  logic              r_done;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_counter   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (r_state != IDLE && bus.abort) begin
      // abort beats a pending acceptance and suppresses the done pulse
      r_state     <= IDLE;
      r_counter   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_counter <= START_ADDR;
            r_busy    <= 1'b1;
            r_state   <= READ;
          end
        end
        READ: begin
          r_out_data  <= bus.rf_rdata;
          r_out_addr  <= r_counter;
          r_out_last  <= (r_counter == LAST_ADDR);
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_counter <= r_counter + ADDR_W'(1);
              r_state   <= READ;
            end
          end
        end
        FINISH: begin
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_counter <= '0;
          r_state   <= IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_out_valid <= 1'b0;
          r_counter   <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // counter is cleared on every return to IDLE, so it doubles as the idle read address
  assign bus.rf_raddr  = r_counter;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule
